// File: rtl/io_bus_decoder_pkg.sv
// Shared types and helpers for the I/O-space decoder and its port matcher.
// Also usable by the memory-side decoder.
package io_bus_pkg;

    localparam int PORT_IDX_W = 4;

    typedef enum logic [1:0] {
        IDLE,
        SELECT,
        RESP
    } io_state_t;

    typedef struct packed {
        logic [15:0] base;
        logic [15:0] mask;
    } io_port_cfg_t;

    // A set mask bit means that address bit must equal the base bit.
    function automatic logic addr_hit(input logic [15:0] addr,
                                      input logic [15:0] base,
                                      input logic [15:0] mask);
        return ((addr ^ base) & mask) == 16'h0000;
    endfunction

endpackage

// File: rtl/io_bus_decoder_if.sv
// Bus between the CPU data port, the decoder and the peripheral ports.
// The slave modport is the decoder's view; master is the view of the core plus peripherals.
interface io_bus_if #(
    parameter int NUM_PORTS = 5
);
    logic                   m_io;
    logic                   m_access;
    logic [15:1]            m_addr;
    logic                   m_wr_en;
    logic [15:0]            m_data_out;
    logic [15:0]            m_data_in;
    logic                   m_ack;
    logic [NUM_PORTS-1:0]   s_cs;
    logic [NUM_PORTS-1:0]   s_ack;
    logic [16*NUM_PORTS-1:0] s_data;
    logic [15:0]            s_data_out;
    logic                   timeout_flag;
    logic [3:0]             timeout_port;

    modport slave (
        input  m_io, m_access, m_addr, m_wr_en, m_data_out, s_ack, s_data,
        output m_data_in, m_ack, s_cs, s_data_out, timeout_flag, timeout_port
    );

    modport master (
        output m_io, m_access, m_addr, m_wr_en, m_data_out, s_ack, s_data,
        input  m_data_in, m_ack, s_cs, s_data_out, timeout_flag, timeout_port
    );

endinterface

// File: rtl/io_bus_decoder_match.sv
// Combinational address matcher over a table of base/mask entries.
// Reports whether any entry hits and the lowest-index hitting entry.
module io_port_match
    import io_bus_pkg::*;
#(
    parameter int                    NUM_PORTS = 5,
    parameter logic [16*NUM_PORTS-1:0] PORT_BASE = {16'hFFFE, 16'hFFFC, 16'hFFFA, 16'hFFF0, 16'hFFF4},
    parameter logic [16*NUM_PORTS-1:0] PORT_MASK = {16'hFFFE, 16'hFFFE, 16'hFFFE, 16'hFFFA, 16'hFFFA}
) (
    input  logic [15:0]           i_addr,
    output logic                  o_hit_any,
    output logic [PORT_IDX_W-1:0] o_sel
);

    io_port_cfg_t w_cfg [NUM_PORTS];

    for (genvar g = 0; g < NUM_PORTS; g++) begin : g_cfg
        assign w_cfg[g].base = PORT_BASE[16*g +: 16];
        assign w_cfg[g].mask = PORT_MASK[16*g +: 16];
    end

    // Scanning downwards lets the lowest hitting index overwrite the rest.
    always_comb begin
        o_hit_any = 1'b0;
        o_sel     = '0;
        for (int i = NUM_PORTS - 1; i >= 0; i--) begin
            if (addr_hit(i_addr, w_cfg[i].base, w_cfg[i].mask)) begin
                o_hit_any = 1'b1;
                o_sel     = PORT_IDX_W'(i);
            end
        end
    end

endmodule

// File: rtl/io_bus_decoder.sv
// Registered one-outstanding-access I/O decoder: selects a peripheral port,
// waits for its ack or a timeout, then returns a single-cycle m_ack to the core.
module io_bus_decoder
    import io_bus_pkg::*;
#(
    parameter int                    NUM_PORTS      = 5,
    parameter logic [16*NUM_PORTS-1:0] PORT_BASE    = {16'hFFFE, 16'hFFFC, 16'hFFFA, 16'hFFF0, 16'hFFF4},
    parameter logic [16*NUM_PORTS-1:0] PORT_MASK    = {16'hFFFE, 16'hFFFE, 16'hFFFE, 16'hFFFA, 16'hFFFA},
    parameter int                    TIMEOUT_CYCLES = 255,
    parameter logic [15:0]           MISS_DATA      = 16'h0000
) (
    input logic      clk,
    input logic      reset_n,
    io_bus_if.slave  bus
);

    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0] TERM = TW'(TIMEOUT_CYCLES - 1);

    io_state_t             r_state;
    logic [PORT_IDX_W-1:0] r_sel;
    logic [TW-1:0]         r_timer;
    logic [NUM_PORTS-1:0]  r_cs;
    logic                  r_ack;
    logic [15:0]           r_data_in;
    logic [15:0]           r_data_out;
    logic                  r_timeout_flag;
    logic [3:0]            r_timeout_port;

    logic                  w_hit_any;
    logic [PORT_IDX_W-1:0] w_match_sel;
    logic [NUM_PORTS-1:0]  w_cs_next;
    logic                  w_sel_ack;
    logic [15:0]           w_sel_data;

    io_port_match #(
        .NUM_PORTS (NUM_PORTS),
        .PORT_BASE (PORT_BASE),
        .PORT_MASK (PORT_MASK)
    ) u_match (
        .i_addr    ({bus.m_addr, 1'b0}),
        .o_hit_any (w_hit_any),
        .o_sel     (w_match_sel)
    );

    // r_cs is one-hot on the selected port during SELECT, so it doubles as the ack/data qualifier.
    always_comb begin
        w_cs_next  = '0;
        w_sel_data = '0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            w_cs_next[i] = (w_match_sel == PORT_IDX_W'(i));
            if (r_cs[i]) begin
                w_sel_data = bus.s_data[16*i +: 16];
            end
        end
        w_sel_ack = |(bus.s_ack & r_cs);
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state        <= IDLE;
            r_sel          <= '0;
            r_timer        <= '0;
            r_cs           <= '0;
            r_ack          <= 1'b0;
            r_data_in      <= '0;
            r_data_out     <= '0;
            r_timeout_flag <= 1'b0;
            r_timeout_port <= '0;
        end else begin
            r_ack <= 1'b0;
            case (r_state)
                IDLE: begin
                    r_timer   <= '0;
                    r_data_in <= '0;
                    if (bus.m_access && bus.m_io) begin
                        r_sel      <= w_match_sel;
                        r_data_out <= bus.m_data_out;
                        if (w_hit_any) begin
                            r_cs    <= w_cs_next;
                            r_state <= SELECT;
                        end else begin
                            r_ack     <= 1'b1;
                            r_data_in <= MISS_DATA;
                            r_state   <= RESP;
                        end
                    end
                end
                SELECT: begin
                    // An ack in the terminal cycle still completes normally.
                    if (w_sel_ack) begin
                        r_cs      <= '0;
                        r_data_in <= w_sel_data;
                        r_ack     <= 1'b1;
                        r_state   <= RESP;
                    end else if (r_timer == TERM) begin
                        r_cs           <= '0;
                        r_data_in      <= MISS_DATA;
                        r_ack          <= 1'b1;
                        r_timeout_flag <= 1'b1;
                        r_timeout_port <= r_sel;
                        r_state        <= RESP;
                    end else begin
                        r_timer <= r_timer + 1'b1;
                    end
                end
                RESP: begin
                    r_data_in <= '0;
                    r_state   <= IDLE;
                end
                default: begin
                    r_cs    <= '0;
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign bus.s_cs         = r_cs;
    assign bus.m_ack        = r_ack;
    assign bus.m_data_in    = r_data_in;
    assign bus.s_data_out   = r_data_out;
    assign bus.timeout_flag = r_timeout_flag;
    assign bus.timeout_port = r_timeout_port;

endmodule

// File: tb/tb_io_bus_decoder.sv
// Self-checking bench for io_bus_decoder: directed corner cases followed by
// random accesses, each compared against a table-driven reference model.
module tb_io_bus_decoder;

    localparam int NP = 5;
    localparam int TO = 8;
    localparam logic [15:0] MISS = 16'hDEAD;
    localparam logic [16*NP-1:0] BASES = {16'h8000, 16'h0008, 16'hFFFA, 16'hFFF0, 16'hFF00};
    localparam logic [16*NP-1:0] MASKS = {16'hF000, 16'h000E, 16'hFFFE, 16'hFFFE, 16'hFFF0};
    localparam int NO_ACK = 100;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    int   checks = 0;
    int   errors = 0;
    logic       modelFlag = 1'b0;
    logic [3:0] modelPort = 4'd0;

    io_bus_if #(.NUM_PORTS(NP)) bus ();

    io_bus_decoder #(
        .NUM_PORTS      (NP),
        .PORT_BASE      (BASES),
        .PORT_MASK      (MASKS),
        .TIMEOUT_CYCLES (TO),
        .MISS_DATA      (MISS)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Lowest table entry whose compared bits equal the byte address, or -1 for unmapped.
    function automatic int refPort(input logic [15:0] a);
        logic [16*NP-1:0] bt;
        logic [16*NP-1:0] mt;
        bt = BASES;
        mt = MASKS;
        for (int i = 0; i < NP; i++) begin
            if (((a ^ bt[16*i +: 16]) & mt[16*i +: 16]) == 16'h0) return i;
        end
        return -1;
    endfunction

    // Latency counts clock edges from driving the request to the edge where the core captures m_ack.
    task automatic applyStimulus(input logic [15:0] a, input logic wr, input logic [15:0] wdata,
                                 input int ackDelay, input logic [NP-1:0] stray,
                                 input bit dropEarly, input string tag);
        int          expPort, expCsCycles, expLat, csCycles, lat;
        logic [NP-1:0] expCs, csOr;
        logic [15:0] expData, gotData, gotOut;
        logic [15:0] portData [NP];
        bit          expTo, gotAck;
        for (int i = 0; i < NP; i++) begin
            portData[i] = 16'($urandom);
            bus.s_data[16*i +: 16] = portData[i];
        end
        expPort = refPort({a[15:1], 1'b0});
        expCs   = (expPort >= 0) ? NP'(1 << expPort) : '0;
        if (expPort < 0) begin
            expData = MISS; expCsCycles = 0; expLat = 2; expTo = 1'b0;
        end else if (ackDelay >= TO) begin
            expData = MISS; expCsCycles = TO; expLat = TO + 2; expTo = 1'b1;
        end else begin
            expData = portData[expPort]; expCsCycles = ackDelay + 1; expLat = ackDelay + 3; expTo = 1'b0;
        end
        bus.m_io = 1'b1;
        bus.m_access = 1'b1;
        bus.m_addr = a[15:1];
        bus.m_wr_en = wr;
        bus.m_data_out = wdata;
        csCycles = 0; csOr = '0; lat = 0; gotAck = 1'b0; gotData = '0; gotOut = '0;
        for (int k = 1; k <= 50 && !gotAck; k++) begin
            @(negedge clk);
            bus.s_ack = '0;
            if (bus.m_ack) begin
                gotAck = 1'b1;
                lat = k + 1;
                gotData = bus.m_data_in;
                gotOut = bus.s_data_out;
                bus.m_access = 1'b0;
                bus.s_ack = stray;
            end else if (bus.s_cs != '0) begin
                csCycles++;
                csOr |= bus.s_cs;
                if (expPort >= 0 && csCycles == ackDelay + 1) bus.s_ack[expPort] = 1'b1;
                if (csCycles == 1) begin
                    bus.s_ack |= stray & ~expCs;
                    if (dropEarly) bus.m_access = 1'b0;
                end
            end
        end
        checkOutput({tag, " ack_seen"}, 32'(gotAck), 32'd1);
        checkOutput({tag, " latency"}, 32'(lat), 32'(expLat));
        checkOutput({tag, " rdata"}, 32'(gotData), 32'(expData));
        checkOutput({tag, " s_data_out"}, 32'(gotOut), 32'(wdata));
        checkOutput({tag, " cs_cycles"}, 32'(csCycles), 32'(expCsCycles));
        checkOutput({tag, " cs_onehot"}, 32'(csOr), 32'(expCs));
        @(negedge clk);
        bus.s_ack = '0;
        bus.m_access = 1'b0;
        if (expTo) begin
            modelFlag = 1'b1;
            modelPort = 4'(expPort);
        end
        checkOutput({tag, " ack_single"}, 32'(bus.m_ack), 32'd0);
        checkOutput({tag, " rdata_idle"}, 32'(bus.m_data_in), 32'd0);
        checkOutput({tag, " to_flag"}, 32'(bus.timeout_flag), 32'(modelFlag));
        checkOutput({tag, " to_port"}, 32'(bus.timeout_port), 32'(modelPort));
    endtask

    initial begin
        logic [15:0] pool [7];
        logic [15:0] a;
        int d;
        pool = '{16'hFFFA, 16'hFFF0, 16'hFF04, 16'h1238, 16'h8ABC, 16'h0060, 16'h0000};
        bus.m_io = 1'b0; bus.m_access = 1'b0; bus.m_addr = '0; bus.m_wr_en = 1'b0;
        bus.m_data_out = '0; bus.s_ack = '0; bus.s_data = '0;
        repeat (3) @(negedge clk);
        checkOutput("reset s_cs", 32'(bus.s_cs), 32'd0);
        checkOutput("reset m_ack", 32'(bus.m_ack), 32'd0);
        checkOutput("reset m_data_in", 32'(bus.m_data_in), 32'd0);
        checkOutput("reset s_data_out", 32'(bus.s_data_out), 32'd0);
        checkOutput("reset to_flag", 32'(bus.timeout_flag), 32'd0);
        reset_n = 1'b1;
        @(negedge clk);

        applyStimulus(16'hFFFA, 1'b1, 16'h1234, 0, '0, 1'b0, "wr_port2");
        applyStimulus(16'h1238, 1'b0, 16'h0F0F, 3, '0, 1'b0, "rd_port3_mask");
        applyStimulus(16'h0060, 1'b0, 16'h5555, 0, '0, 1'b0, "rd_unmapped");
        applyStimulus(16'hFFF0, 1'b0, 16'h0001, NO_ACK, '0, 1'b0, "timeout_port1");
        applyStimulus(16'h8ABC, 1'b1, 16'hBEEF, 1, '0, 1'b0, "good_after_to");
        applyStimulus(16'hFF08, 1'b0, 16'h0002, 1, 5'b10000, 1'b0, "overlap_stray");
        applyStimulus(16'h8002, 1'b0, 16'h0003, TO - 1, '0, 1'b0, "ack_at_timeout");
        applyStimulus(16'hFFFA, 1'b0, 16'h0004, 2, '0, 1'b1, "drop_access");

        bus.m_io = 1'b0;
        bus.m_access = 1'b1;
        bus.m_addr = 15'h7FFD;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            checkOutput("memory_path cs", 32'(bus.s_cs), 32'd0);
            checkOutput("memory_path ack", 32'(bus.m_ack), 32'd0);
        end
        bus.m_access = 1'b0;
        @(negedge clk);

        bus.m_io = 1'b1;
        bus.m_access = 1'b1;
        bus.m_addr = 15'h7FF8;
        repeat (3) @(negedge clk);
        checkOutput("pre_reset cs", 32'(bus.s_cs), 32'd2);
        reset_n = 1'b0;
        bus.m_access = 1'b0;
        @(negedge clk);
        checkOutput("mid_reset cs", 32'(bus.s_cs), 32'd0);
        checkOutput("mid_reset ack", 32'(bus.m_ack), 32'd0);
        checkOutput("mid_reset to_flag", 32'(bus.timeout_flag), 32'd0);
        checkOutput("mid_reset to_port", 32'(bus.timeout_port), 32'd0);
        modelFlag = 1'b0;
        modelPort = 4'd0;
        reset_n = 1'b1;
        @(negedge clk);
        applyStimulus(16'hFFF0, 1'b0, 16'h0000, 0, '0, 1'b0, "post_reset");

        for (int n = 0; n < 24; n++) begin
            a = pool[$urandom_range(0, 6)];
            if (a == 16'h0000) a = 16'($urandom);
            d = ($urandom_range(0, 5) == 0) ? NO_ACK : int'($urandom_range(0, TO - 1));
            applyStimulus(a, 1'($urandom), 16'($urandom), d, NP'($urandom),
                          1'($urandom_range(0, 3) == 0), "random");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
